// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared widths, rounding and saturation constants for the FIR
//            output conditioning stage.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DEF_IN_W  = 41;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 15;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic longint rnd_const(input int shift);
        return 64'sd1 <<< (shift - 1);
    endfunction

    localparam longint OUT_MAX = sat_max(DEF_OUT_W);
    localparam longint OUT_MIN = sat_min(DEF_OUT_W);
    localparam longint RND     = rnd_const(DEF_SHIFT);

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_fifo
// Purpose  : Small synchronous FIFO; the head is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_stage
// Purpose  : Edge-captures FIR accumulator results, rounds half-up, shifts,
//            saturates and buffers them toward the output consumer.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_stage
    import fir_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          din,
    input  logic                     din_valid,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     sat_flag,
    input  logic                     sat_clr,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic signed [IN_W:0] C_MAX = (IN_W+1)'(sat_max(OUT_W));
    localparam logic signed [IN_W:0] C_MIN = (IN_W+1)'(sat_min(OUT_W));
    localparam logic signed [IN_W:0] C_RND = (IN_W+1)'(rnd_const(SHIFT));
    localparam logic [OUT_W-1:0]     Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                   din_valid_q;
    logic                   cap;
    logic signed [IN_W:0]   din_ext;
    logic signed [IN_W:0]   rounded;
    logic                   s1_valid;
    logic signed [IN_W:0]   s1;
    logic                   s2_valid;
    logic [OUT_W-1:0]       s2;
    logic                   sat_hit;
    logic [OUT_W-1:0]       sat_val;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    assign cap = din_valid & ~din_valid_q;

    // One guard bit keeps the rounding add from overflowing at full scale.
    always_comb begin
        din_ext = $signed({din[IN_W-1], din});
        rounded = (din_ext + C_RND) >>> SHIFT;
    end

    always_comb begin
        sat_hit = 1'b0;
        sat_val = s1[OUT_W-1:0];
        if (s1 > C_MAX) begin
            sat_hit = 1'b1;
            sat_val = Q_MAX;
        end else if (s1 < C_MIN) begin
            sat_hit = 1'b1;
            sat_val = Q_MIN;
        end
    end

    assign pop  = dout_valid & dout_ready;
    assign drop = s2_valid & fifo_full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_valid_q <= 1'b0;
            s1_valid    <= 1'b0;
            s1          <= '0;
            s2_valid    <= 1'b0;
            s2          <= '0;
            sat_flag    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            din_valid_q <= din_valid;
            s1_valid    <= cap;
            if (cap) begin
                s1 <= rounded;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2 <= sat_val;
            end
            // A new saturation event takes priority over a clear request.
            if (s1_valid && sat_hit) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    fir_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .pop   (pop),
        .wdata (s2),
        .rdata (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign dout_valid = ~fifo_empty;

endmodule
`default_nettype wire
